fifo_rd_packer: RTL
===================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of the async FIFO, in the FIFO read-clock domain. Pulls WIDTH-bit
//  entries whenever the FIFO is non-empty and space exists, packs RATIO entries into one
//  wide word, and presents it on a valid/ready stream with byte-lane enables. A flush
//  request emits a partially filled word marked last, so tail data is never stranded.
// PARAMETERS
//  WIDTH  8  FIFO entry width in bits; must match the FIFO WIDTH
//  RATIO  4  entries per output word, >=2; OW = WIDTH*RATIO (localparam)
// PORTS
//  clk         in   1       FIFO read clock; the only clock in this block
//  rst         in   1       asynchronous, active-low reset
//  fifo_empty  in   1       FIFO empty flag
//  fifo_dout   in   WIDTH   FIFO read data; valid only in a cycle with fifo_pull=1
//  fifo_pull   out  1       FIFO pull request
//  flush       in   1       single-cycle pulse: emit the partial word now
//  out_valid   out  1       output word valid
//  out_ready   in   1       downstream accepts the word when high with out_valid
//  out_data    out  OW      packed word; lane 0 (LSBs) = oldest entry
//  out_be      out  RATIO   lane enables; bit i=1 -> lane i holds data
//  out_last    out  1       word was closed by a flush
//  busy        out  1       accumulator non-empty, output queue non-empty, or flush pending
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): cnt=0, state=FILL, queue emptied. out_valid=0,
//    out_data=0, out_be=0, out_last=0, fifo_pull=0, busy=0. Reset mid-operation drops
//    the partial word and all queued words with no flush.
//  - fifo_pull = !fifo_empty && state==FILL && (cnt<RATIO-1 || queue has a free slot).
//    fifo_pull is combinational. fifo_dout is sampled on the same clk edge as the pull;
//    fifo_dout is never sampled at any other time.
//  - Accumulator: cnt is $clog2(RATIO)+1 bits wide. A captured entry goes to lane cnt,
//    then cnt increments. On the RATIO-th entry, {data, be=all ones, last=0} is enqueued
//    on the same edge and cnt returns to 0. Unused lanes are zero-filled.
//  - Latency: out_valid rises on the cycle after the final entry of a word is pulled
//    (1 clk), provided the queue was empty.
//  - Output queue: 2-entry FIFO holding {data, be, last}. out_* always reflect the head.
//    While out_valid=1 and out_ready=0, out_data, out_be and out_last stay stable.
//    Enqueue and dequeue in the same cycle are both allowed when the queue is full.
//    Word order is strictly preserved.
//  - FSM:
//      FILL -> FLUSH on flush=1 when cnt>0, or when an entry is captured in the same
//      cycle as the flush. The byte captured in the flush cycle belongs to the flushed
//      word.
//      FLUSH: fifo_pull is held at 0. When the queue has a slot, the FSM enqueues
//      {data, be=(1<<cnt)-1, last=1}, sets cnt=0 and returns to FILL.
//      If the queue has a slot in the flush cycle itself, the enqueue happens on that
//      edge and FLUSH lasts 0 cycles.
//  - A flush with cnt==0 and no capture emits nothing and is dropped; a flush seen while
//    in FLUSH is also dropped.
//  - A flush on the cycle the RATIO-th entry completes a word produces the full word with
//    last=1 and no extra empty word.
//  - Empty FIFO: no pull and no state change. A partial word waits indefinitely until
//    more data or a flush arrives.
// STRUCTURE
//  - fifo_pkg: state typedef (enum FILL, FLUSH) and function be_mask(cnt) returning
//    (1<<cnt)-1.
//  - Sub-module out_skid2: the 2-entry {data, be, last} output queue with valid/ready
//    and a free-slot flag. This module instantiates it once and contains the
//    accumulator and FSM.
// TESTING
//  1. Reset: hold rst=0 with fifo_empty=0 -> fifo_pull=0, out_valid=0, out_be=0, busy=0.
//  2. Entries 11,22,33,44 with out_ready=1 -> 4 pulls, then one clk later
//     out_data=0x44332211, out_be=4'hF, out_last=0.
//  3. out_ready=0 with 12 entries in the FIFO -> exactly 11 pulls, then fifo_pull=0.
//     Raise out_ready -> three words drained in order, the third completed by the 12th pull.
//  4. Entries AA,BB, then a flush pulse -> out_data=0x0000BBAA, out_be=4'b0011,
//     out_last=1, busy=0 afterwards.
//  5. Flush in the same cycle as the 3rd pull (entries 01,02,03) -> out_data=0x00030201,
//     out_be=4'b0111, out_last=1. Flush with cnt==0 -> no word emitted.
//  6. Queue full, 2 entries accumulated, flush, out_ready=0 for 5 clks -> FSM stays in
//     FLUSH and fifo_pull=0. Then out_ready=1 -> two full words, then the partial word
//     with be=4'b0011 and last=1.
//  7. Reset asserted mid-fill with 1 word queued -> out_valid=0 immediately. The next 4
//     entries form a fresh word starting at lane 0.

Source files
------------

// File: rtl/fifo_rd_packer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fifo_rd_packer_pkg                                               |
// | Brief    : Shared state encoding and lane-mask helper for fifo_rd_packer.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package fifo_rd_packer_pkg;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Low 'cnt' bits set: enables exactly the lanes filled so far.
  function automatic logic [31:0] be_mask(input logic [31:0] cnt);
    return (32'd1 << cnt) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_packer_out_skid2.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fifo_rd_packer_out_skid2                                         |
// | Brief    : Two-entry {data, be, last} output queue with valid/ready.        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module fifo_rd_packer_out_skid2
  import fifo_rd_packer_pkg::*;
#(
  parameter int DW = 32,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [BW-1:0] push_be,
  input  logic          push_last,
  output logic          slot_free,
  output logic          not_empty,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [BW-1:0] out_be,
  output logic          out_last
);

  logic [DW-1:0] r_data [2];
  logic [BW-1:0] r_be   [2];
  logic          r_last [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;
  logic          w_pop;

  assign w_pop     = out_valid && out_ready;
  assign out_valid = (r_count != 2'd0);
  assign not_empty = out_valid;
  // A word leaving this cycle frees its slot for a same-edge enqueue.
  assign slot_free = (r_count != 2'd2) || w_pop;

  assign out_data = r_data[r_rd_ptr];
  assign out_be   = r_be[r_rd_ptr];
  assign out_last = r_last[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_be[0]   <= '0;
      r_be[1]   <= '0;
      r_last[0] <= 1'b0;
      r_last[1] <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (push) begin
        r_data[r_wr_ptr] <= push_data;
        r_be[r_wr_ptr]   <= push_be;
        r_last[r_wr_ptr] <= push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fifo_rd_packer                                                   |
// | Brief    : Packs RATIO FIFO entries into one wide word; flush emits tails.  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_dout,
  output logic                   fifo_pull,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_be,
  output logic                   out_last,
  output logic                   busy
);

  localparam int             c_ow   = WIDTH * RATIO;
  localparam int             c_cw   = $clog2(RATIO) + 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(RATIO - 1);

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic [c_ow-1:0]   r_acc;

  state_t            w_state_nxt;
  logic [c_cw-1:0]   w_cnt_cap;
  logic [c_cw-1:0]   w_cnt_nxt;
  logic [c_ow-1:0]   w_acc_cap;
  logic [c_ow-1:0]   w_acc_nxt;
  logic              w_slot;
  logic              w_q_nonempty;
  logic              w_push;
  logic [RATIO-1:0]  w_push_be;
  logic              w_push_last;

  // Held low in reset so the FIFO is never popped by a block that would discard the entry.
  assign fifo_pull = rst && !fifo_empty && (r_state == ST_FILL) &&
                     ((r_cnt < c_last) || w_slot);

  always_comb begin
    w_acc_cap = r_acc;
    for (int i = 0; i < RATIO; i++) begin
      if (fifo_pull && (r_cnt == c_cw'(i))) begin
        w_acc_cap[i*WIDTH +: WIDTH] = fifo_dout;
      end
    end
    w_cnt_cap   = r_cnt + c_cw'(fifo_pull);
    w_push      = 1'b0;
    w_push_be   = RATIO'(be_mask(32'(w_cnt_cap)));
    w_push_last = 1'b1;
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_cap;
    w_acc_nxt   = w_acc_cap;
    case (r_state)
      ST_FILL: begin
        if (fifo_pull && (r_cnt == c_last)) begin
          w_push      = 1'b1;
          w_push_last = flush;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
        end else if (flush && (w_cnt_cap != '0)) begin
          if (w_slot) begin
            w_push    = 1'b1;
            w_cnt_nxt = '0;
            w_acc_nxt = '0;
          end else begin
            w_state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (w_slot) begin
          w_push      = 1'b1;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  fifo_rd_packer_out_skid2 #(
    .DW (c_ow),
    .BW (RATIO)
  ) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_acc_cap),
    .push_be   (w_push_be),
    .push_last (w_push_last),
    .slot_free (w_slot),
    .not_empty (w_q_nonempty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_last  (out_last)
  );

  assign busy = (r_cnt != '0) || w_q_nonempty || (r_state == ST_FLUSH);

endmodule
`default_nettype wire
